// File: rtl/mant_div_if.sv
// Operand/result handshake bundle for the iterative mantissa divider.
// Master drives operands and result acceptance; slave is the divider.
interface mant_div_if #(parameter int W = 24);
   logic           in_valid;
   logic           in_ready;
   logic [W-1:0]   a;
   logic [W-1:0]   b;
   logic           out_valid;
   logic           out_ready;
   logic [2*W-1:0] q;
   logic [W-1:0]   r;
   logic           dz;

   modport master (
      output in_valid, a, b, out_ready,
      input  in_ready, out_valid, q, r, dz
   );

   modport slave (
      input  in_valid, a, b, out_ready,
      output in_ready, out_valid, q, r, dz
   );
endinterface

// File: rtl/mant_div_iter.sv
// Radix-2 restoring divider: q = floor({a,W'b0}/b), one quotient bit per clock.
// Results are held in dedicated output registers until the next completion.
module mant_div_iter #(
   parameter int W  = 24,
   parameter int CW = 6
) (
   input  logic     clk,
   input  logic     rst_n,
   mant_div_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      ZERO,
      DONE
   } state_t;

   state_t         r_state;
   state_t         w_state_nx;
   logic [CW-1:0]  r_cnt;
   logic [2*W-1:0] r_div;
   logic [2*W-2:0] r_quo;
   logic [W-1:0]   r_b;
   logic [W-1:0]   r_rem;
   logic [2*W-1:0] r_q;
   logic [W-1:0]   r_r;
   logic           r_dz;

   logic           w_acc;
   logic           w_last;
   logic           w_ge;
   logic [W:0]     w_rem_sh;
   logic [W-1:0]   w_rem_nx;
   logic [2*W-1:0] w_quo_nx;

   assign w_acc  = bus.in_valid && (r_state == IDLE);
   assign w_last = (r_cnt == CW'(2*W-1));

   // Compare is W+1 wide; the restored difference is < b so fits W bits.
   assign w_rem_sh = {r_rem, r_div[2*W-1]};
   assign w_ge     = (w_rem_sh >= {1'b0, r_b});
   assign w_rem_nx = w_ge ? (w_rem_sh[W-1:0] - r_b) : w_rem_sh[W-1:0];
   assign w_quo_nx = {r_quo, w_ge};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nx;
   end

   always_comb begin
      w_state_nx = r_state;
      unique case (r_state)
         IDLE: begin
            if (w_acc) w_state_nx = (bus.b == '0) ? ZERO : BUSY;
         end
         BUSY: begin
            if (w_last) w_state_nx = DONE;
         end
         ZERO: begin
            w_state_nx = DONE;
         end
         DONE: begin
            if (bus.out_ready) w_state_nx = IDLE;
         end
         default: w_state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
         r_div <= '0;
         r_quo <= '0;
         r_b   <= '0;
         r_rem <= '0;
         r_q   <= '0;
         r_r   <= '0;
         r_dz  <= 1'b0;
      end else begin
         if (w_acc) begin
            r_div <= {bus.a, {W{1'b0}}};
            r_b   <= bus.b;
            r_rem <= '0;
            r_quo <= '0;
            r_cnt <= '0;
         end
         if (r_state == BUSY) begin
            r_rem <= w_rem_nx;
            r_quo <= w_quo_nx[2*W-2:0];
            r_div <= {r_div[2*W-2:0], 1'b0};
            r_cnt <= r_cnt + CW'(1);
            if (w_last) begin
               r_q  <= w_quo_nx;
               r_r  <= w_rem_nx;
               r_dz <= 1'b0;
            end
         end
         if (r_state == ZERO) begin
            r_q  <= '1;
            r_r  <= '0;
            r_dz <= 1'b1;
         end
      end
   end

   assign bus.in_ready  = (r_state == IDLE);
   assign bus.out_valid = (r_state == DONE);
   assign bus.q         = r_q;
   assign bus.r         = r_r;
   assign bus.dz        = r_dz;

endmodule

// File: tb/tb_mant_div_iter.sv
// Directed bench for mant_div_iter: latency, results, back-pressure,
// divide-by-zero, mid-operation reset and a short normalized sweep.
module tb_mant_div_iter;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   mant_div_if #(.W(24)) bus ();

   mant_div_iter #(.W(24), .CW(6)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   int n_chk = 0;
   int n_err = 0;
   int cyc;
   logic [47:0] hq;
   logic [23:0] hr;
   logic [23:0] ra, rb;
   logic [71:0] num, eq, er;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic start(input logic [23:0] a, input logic [23:0] b,
                        input string tag);
      @(negedge clk);
      chk({tag, ":in_ready"}, 64'(bus.in_ready), 64'd1);
      bus.in_valid = 1'b1;
      bus.a        = a;
      bus.b        = b;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.a        = 24'($urandom);
      bus.b        = 24'($urandom);
      chk({tag, ":busy_rdy"}, 64'(bus.in_ready), 64'd0);
   endtask

   task automatic wait_done(input int lat, input string tag);
      cyc = 0;
      while (!bus.out_valid && cyc < 200) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      chk({tag, ":latency"}, 64'(cyc), 64'(lat));
   endtask

   task automatic res(input logic [47:0] q, input logic [23:0] r,
                      input logic dz, input string tag);
      chk({tag, ":q"}, 64'(bus.q), 64'(q));
      chk({tag, ":r"}, 64'(bus.r), 64'(r));
      chk({tag, ":dz"}, 64'(bus.dz), 64'(dz));
   endtask

   task automatic take(input string tag);
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      chk({tag, ":ovalid_clr"}, 64'(bus.out_valid), 64'd0);
      chk({tag, ":idle"}, 64'(bus.in_ready), 64'd1);
   endtask

   initial begin
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.a         = '0;
      bus.b         = '0;
      #2 rst_n = 1'b0;
      #10;
      chk("rst:in_ready", 64'(bus.in_ready), 64'd1);
      chk("rst:out_valid", 64'(bus.out_valid), 64'd0);
      res(48'h0, 24'h0, 1'b0, "rst");
      @(negedge clk);
      rst_n = 1'b1;

      start(24'h800000, 24'h800000, "one");
      wait_done(48, "one");
      res(48'h000001000000, 24'h0, 1'b0, "one");
      take("one");

      start(24'h800000, 24'hC00000, "twothirds");
      wait_done(48, "twothirds");
      res(48'h000000AAAAAA, 24'h800000, 1'b0, "twothirds");
      take("twothirds");

      start(24'hFFFFFF, 24'h000001, "bydone");
      wait_done(48, "bydone");
      res(48'hFFFFFF000000, 24'h0, 1'b0, "bydone");
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         bus.in_valid = i[0];
         bus.a        = 24'h400000;
         bus.b        = 24'h000003;
         @(posedge clk);
         #1;
         chk("bp:out_valid", 64'(bus.out_valid), 64'd1);
         chk("bp:in_ready", 64'(bus.in_ready), 64'd0);
         chk("bp:q", 64'(bus.q), 64'h0000FFFFFF000000);
         chk("bp:r", 64'(bus.r), 64'd0);
      end
      bus.in_valid = 1'b0;
      take("bp");

      start(24'h123456, 24'h000000, "dz");
      wait_done(1, "dz");
      res(48'hFFFFFFFFFFFF, 24'h0, 1'b1, "dz");
      take("dz");

      start(24'hC00000, 24'h800000, "after_dz");
      chk("after_dz:hold_q", 64'(bus.q), 64'h0000FFFFFFFFFFFF);
      wait_done(48, "after_dz");
      res(48'h000001800000, 24'h0, 1'b0, "after_dz");
      take("after_dz");

      start(24'hFFFFFF, 24'h800000, "abort");
      repeat (19) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("abort:out_valid", 64'(bus.out_valid), 64'd0);
      chk("abort:in_ready", 64'(bus.in_ready), 64'd1);
      res(48'h0, 24'h0, 1'b0, "abort");
      @(negedge clk);
      rst_n = 1'b1;
      start(24'hFFFFFF, 24'h800000, "post_rst");
      wait_done(48, "post_rst");
      res(48'h000001FFFFFE, 24'h0, 1'b0, "post_rst");
      take("post_rst");

      for (int i = 0; i < 20; i++) begin
         ra  = 24'($urandom) | 24'h800000;
         rb  = 24'($urandom) | 24'h800000;
         num = {24'h0, ra, 24'h0};
         eq  = num / {48'h0, rb};
         er  = num % {48'h0, rb};
         start(ra, rb, $sformatf("rnd%0d", i));
         wait_done(48, $sformatf("rnd%0d", i));
         hq = bus.q;
         hr = bus.r;
         chk($sformatf("rnd%0d:q", i), 64'(hq), 64'(eq));
         chk($sformatf("rnd%0d:r", i), 64'(hr), 64'(er));
         take($sformatf("rnd%0d", i));
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
